// File: rtl/qenc_mvd_binarizer_if.sv
// MVD binarizer bundle: pair request from the CU FSM plus the bin stream to the arithmetic engine.
// mvd_bin_cnt exists only when MVD_BIN_CNT_EN is defined.
interface qenc_mvd_binarizer_if #(
  parameter int MVD_W = 16
);
  logic             mvd_start;
  logic [MVD_W-1:0] mvd_x;
  logic [MVD_W-1:0] mvd_y;
  logic             mvd_rdy;
  logic             bin_vld;
  logic             bin_rdy;
  logic             bin_val;
  logic             bin_ep;
  logic [9:0]       bin_ctx_addr;
  logic             mvd_done;
`ifdef MVD_BIN_CNT_EN
  logic [7:0]       mvd_bin_cnt;
`endif

  // master = the binarizer, slave = CU FSM / engine side
  modport master (
    input  mvd_start,
    input  mvd_x,
    input  mvd_y,
    input  bin_rdy,
    output mvd_rdy,
    output bin_vld,
    output bin_val,
    output bin_ep,
    output bin_ctx_addr,
    output mvd_done
`ifdef MVD_BIN_CNT_EN
    ,
    output mvd_bin_cnt
`endif
  );

  modport slave (
    output mvd_start,
    output mvd_x,
    output mvd_y,
    output bin_rdy,
    input  mvd_rdy,
    input  bin_vld,
    input  bin_val,
    input  bin_ep,
    input  bin_ctx_addr,
    input  mvd_done
`ifdef MVD_BIN_CNT_EN
    ,
    input  mvd_bin_cnt
`endif
  );
endinterface

// File: rtl/qenc_mvd_binarizer.sv
// CABAC encoder MVD binarizer: one (x,y) pair -> gt0/gt1 context bins, EG1 + sign bypass bins, 1 bin/cycle.
// Optional MVD_BIN_CNT_EN adds mvd_bin_cnt (bins transferred for the current pair).
module qenc_mvd_binarizer #(
  parameter int         MVD_W        = 16,
  parameter logic [9:0] CTX_GT0_ADDR = 10'd150,
  parameter logic [9:0] CTX_GT1_ADDR = 10'd152
) (
  input  logic                  clk,
  input  logic                  rst_n,
  qenc_mvd_binarizer_if.master  mvd_if
);

  typedef enum logic [3:0] {
    S_IDLE, S_GT0_X, S_GT0_Y, S_GT1_X, S_GT1_Y,
    S_EGP_X, S_EGS_X, S_SGN_X, S_EGP_Y, S_EGS_Y, S_SGN_Y, S_DONE
  } state_t;

  localparam logic [MVD_W-1:0] ONE   = MVD_W'(1);
  localparam logic [MVD_W-1:0] TWO   = MVD_W'(2);
  localparam logic [MVD_W:0]   ONE_W = (MVD_W+1)'(1);

  state_t           r_state;
  logic [MVD_W-1:0] r_abs_x, r_abs_y, r_v;
  logic             r_neg_x, r_neg_y;
  logic [4:0]       r_k;
  logic             r_bin_vld, r_bin_val, r_bin_ep, r_mvd_rdy, r_mvd_done;
  logic [9:0]       r_bin_ctx;

  logic             w_cap, w_xfer;
  logic [MVD_W-1:0] w_in_abs_x, w_in_abs_y, w_abs_x, w_abs_y;
  logic             w_neg_x, w_neg_y;
  logic             w_gt0x, w_gt0y, w_gt1x, w_gt1y;
  state_t           w_xpath, w_ypath, w_nxt_state;
  logic [MVD_W-1:0] w_nxt_v;
  logic [4:0]       w_nxt_k;
  logic             w_o_vld, w_o_val, w_o_ep;
  logic [9:0]       w_o_ctx;

  // EG1 prefix bin: 1 while the remainder still covers 2^k
  function automatic logic egp_bit(input logic [MVD_W-1:0] v, input logic [4:0] k);
    return {1'b0, v} >= (ONE_W << k);
  endfunction

  function automatic logic egs_bit(input logic [MVD_W-1:0] v, input logic [4:0] k);
    return |(v & (ONE << (k - 5'd1)));
  endfunction

  assign w_cap  = (r_state == S_IDLE) && mvd_if.mvd_start;
  assign w_xfer = r_bin_vld && mvd_if.bin_rdy;

  // Two's-complement negate in MVD_W bits: the most negative value lands on 2^(MVD_W-1)
  assign w_in_abs_x = mvd_if.mvd_x[MVD_W-1] ? (~mvd_if.mvd_x + ONE) : mvd_if.mvd_x;
  assign w_in_abs_y = mvd_if.mvd_y[MVD_W-1] ? (~mvd_if.mvd_y + ONE) : mvd_if.mvd_y;

  assign w_abs_x = w_cap ? w_in_abs_x : r_abs_x;
  assign w_abs_y = w_cap ? w_in_abs_y : r_abs_y;
  assign w_neg_x = w_cap ? mvd_if.mvd_x[MVD_W-1] : r_neg_x;
  assign w_neg_y = w_cap ? mvd_if.mvd_y[MVD_W-1] : r_neg_y;
  assign w_gt0x  = |w_abs_x;
  assign w_gt0y  = |w_abs_y;
  assign w_gt1x  = |w_abs_x[MVD_W-1:1];
  assign w_gt1y  = |w_abs_y[MVD_W-1:1];

  assign w_ypath = w_gt1y ? S_EGP_Y : (w_gt0y ? S_SGN_Y : S_DONE);
  assign w_xpath = w_gt1x ? S_EGP_X : (w_gt0x ? S_SGN_X : w_ypath);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_v     = r_v;
    w_nxt_k     = r_k;
    case (r_state)
      S_IDLE:  if (mvd_if.mvd_start) w_nxt_state = S_GT0_X;
      S_GT0_X: if (w_xfer) w_nxt_state = S_GT0_Y;
      S_GT0_Y: if (w_xfer) w_nxt_state = w_gt0x ? S_GT1_X : (w_gt0y ? S_GT1_Y : w_xpath);
      S_GT1_X: if (w_xfer) w_nxt_state = w_gt0y ? S_GT1_Y : w_xpath;
      S_GT1_Y: if (w_xfer) w_nxt_state = w_xpath;
      S_EGP_X, S_EGP_Y: begin
        if (w_xfer) begin
          if (egp_bit(r_v, r_k)) begin
            w_nxt_v = r_v - (ONE << r_k);
            w_nxt_k = r_k + 5'd1;
          end else begin
            w_nxt_state = (r_state == S_EGP_X) ? S_EGS_X : S_EGS_Y;
          end
        end
      end
      S_EGS_X, S_EGS_Y: begin
        if (w_xfer) begin
          if (r_k == 5'd1) w_nxt_state = (r_state == S_EGS_X) ? S_SGN_X : S_SGN_Y;
          else             w_nxt_k = r_k - 5'd1;
        end
      end
      S_SGN_X: if (w_xfer) w_nxt_state = w_ypath;
      S_SGN_Y: if (w_xfer) w_nxt_state = S_DONE;
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
    // Entering a component's EG1 prefix reloads the remainder and order
    if (w_nxt_state == S_EGP_X && r_state != S_EGP_X) begin
      w_nxt_v = w_abs_x - TWO;
      w_nxt_k = 5'd1;
    end else if (w_nxt_state == S_EGP_Y && r_state != S_EGP_Y) begin
      w_nxt_v = w_abs_y - TWO;
      w_nxt_k = 5'd1;
    end
  end

  always_comb begin
    w_o_vld = 1'b1;
    w_o_val = 1'b0;
    w_o_ep  = 1'b1;
    w_o_ctx = 10'd0;
    case (w_nxt_state)
      S_GT0_X: begin w_o_ep = 1'b0; w_o_ctx = CTX_GT0_ADDR; w_o_val = w_gt0x; end
      S_GT0_Y: begin w_o_ep = 1'b0; w_o_ctx = CTX_GT0_ADDR; w_o_val = w_gt0y; end
      S_GT1_X: begin w_o_ep = 1'b0; w_o_ctx = CTX_GT1_ADDR; w_o_val = w_gt1x; end
      S_GT1_Y: begin w_o_ep = 1'b0; w_o_ctx = CTX_GT1_ADDR; w_o_val = w_gt1y; end
      S_EGP_X, S_EGP_Y: w_o_val = egp_bit(w_nxt_v, w_nxt_k);
      S_EGS_X, S_EGS_Y: w_o_val = egs_bit(w_nxt_v, w_nxt_k);
      S_SGN_X: w_o_val = w_neg_x;
      S_SGN_Y: w_o_val = w_neg_y;
      default: begin w_o_vld = 1'b0; w_o_ep = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_abs_x    <= '0;
      r_abs_y    <= '0;
      r_neg_x    <= 1'b0;
      r_neg_y    <= 1'b0;
      r_v        <= '0;
      r_k        <= 5'd0;
      r_bin_vld  <= 1'b0;
      r_bin_val  <= 1'b0;
      r_bin_ep   <= 1'b0;
      r_bin_ctx  <= 10'd0;
      r_mvd_rdy  <= 1'b1;
      r_mvd_done <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_abs_x    <= w_abs_x;
      r_abs_y    <= w_abs_y;
      r_neg_x    <= w_neg_x;
      r_neg_y    <= w_neg_y;
      r_v        <= w_nxt_v;
      r_k        <= w_nxt_k;
      r_bin_vld  <= w_o_vld;
      r_bin_val  <= w_o_val;
      r_bin_ep   <= w_o_ep;
      r_bin_ctx  <= w_o_ctx;
      r_mvd_rdy  <= (w_nxt_state == S_IDLE);
      r_mvd_done <= (w_nxt_state == S_DONE);
    end
  end

  assign mvd_if.mvd_rdy      = r_mvd_rdy;
  assign mvd_if.bin_vld      = r_bin_vld;
  assign mvd_if.bin_val      = r_bin_val;
  assign mvd_if.bin_ep       = r_bin_ep;
  assign mvd_if.bin_ctx_addr = r_bin_ctx;
  assign mvd_if.mvd_done     = r_mvd_done;

`ifdef MVD_BIN_CNT_EN
  logic [7:0] r_bin_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_bin_cnt <= 8'd0;
    else if (w_cap)  r_bin_cnt <= 8'd0;
    else if (w_xfer) r_bin_cnt <= r_bin_cnt + 8'd1;
  end

  assign mvd_if.mvd_bin_cnt = r_bin_cnt;
`endif

endmodule

// File: tb/tb_qenc_mvd_binarizer.sv
// Bench for qenc_mvd_binarizer: directed + random mvd pairs against an arithmetic bin-sequence model.
module tb_qenc_mvd_binarizer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qenc_mvd_binarizer_if #(.MVD_W(16)) mvd_if ();

  qenc_mvd_binarizer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mvd_if (mvd_if)
  );

  typedef struct packed {
    logic       val;
    logic       ep;
    logic [9:0] ctx;
  } bin_t;

  bin_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int val, input int ep, input int ctx);
    bin_t b;
    b.val = (val != 0);
    b.ep  = (ep != 0);
    b.ctx = 10'(ctx);
    exp_q.push_back(b);
  endtask

  // Order-1 Exp-Golomb: unary prefix over growing 2^k, then k-bit suffix MSB first
  task automatic eg1(input int v);
    int k = 1;
    while (v >= (1 << k)) begin
      push(1, 1, 0);
      v -= (1 << k);
      k++;
    end
    push(0, 1, 0);
    for (int i = k - 1; i >= 0; i--) push((v >> i) & 1, 1, 0);
  endtask

  task automatic build(input int x, input int y);
    int ax = (x < 0) ? -x : x;
    int ay = (y < 0) ? -y : y;
    exp_q.delete();
    push(ax > 0, 0, 150);
    push(ay > 0, 0, 150);
    if (ax > 0) push(ax > 1, 0, 152);
    if (ay > 0) push(ay > 1, 0, 152);
    if (ax > 1) eg1(ax - 2);
    if (ax > 0) push(x < 0, 1, 0);
    if (ay > 1) eg1(ay - 2);
    if (ay > 0) push(y < 0, 1, 0);
  endtask

  // rdy_mode 0: bin_rdy=1 except the forced stall; 1: random bin_rdy
  task automatic run_pair(input int x, input int y, input int rdy_mode,
                          input int stall_idx, input int stall_len, input bit busy_start);
    int  n;
    int  idx = 0;
    int  stalls = 0;
    int  stall_total = 0;
    bit  done_seen = 0;
    bit  rdy;
    logic [15:0] xs;
    logic [15:0] ys;
    build(x, y);
    n = exp_q.size();
    xs = x[15:0];
    ys = y[15:0];
    @(negedge clk);
    chk("rdy_idle", 32'(mvd_if.mvd_rdy), 1);
    mvd_if.mvd_x     = xs;
    mvd_if.mvd_y     = ys;
    mvd_if.mvd_start = 1'b1;
    mvd_if.bin_rdy   = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 400 && !done_seen; c++) begin
      if (c > 1) @(negedge clk);
      mvd_if.mvd_start = 1'b0;
      if (idx < n) begin
        chk("bin_vld", 32'(mvd_if.bin_vld), 1);
        chk("bin_val", 32'(mvd_if.bin_val), 32'(exp_q[idx].val));
        chk("bin_ep", 32'(mvd_if.bin_ep), 32'(exp_q[idx].ep));
        chk("bin_ctx", 32'(mvd_if.bin_ctx_addr), 32'(exp_q[idx].ctx));
        chk("busy_rdy", 32'(mvd_if.mvd_rdy), 0);
        if (idx == stall_idx && stalls < stall_len) begin
          rdy = 1'b0;
          stalls++;
        end else begin
          rdy = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (busy_start && c == 2) begin
          mvd_if.mvd_x     = 16'h1234;
          mvd_if.mvd_y     = 16'h8001;
          mvd_if.mvd_start = 1'b1;
        end
        if (rdy) idx++;
        else     stall_total++;
        mvd_if.bin_rdy = rdy;
      end else begin
        chk("vld_in_done", 32'(mvd_if.bin_vld), 0);
        chk("mvd_done", 32'(mvd_if.mvd_done), 1);
        chk("done_cycle", c, n + stall_total + 1);
        done_seen = 1;
      end
    end
    if (!done_seen) chk("timeout", 0, 1);
    @(negedge clk);
    chk("done_pulse_end", 32'(mvd_if.mvd_done), 0);
    chk("rdy_after_done", 32'(mvd_if.mvd_rdy), 1);
`ifdef MVD_BIN_CNT_EN
    chk("bin_cnt", 32'(mvd_if.mvd_bin_cnt), n);
`endif
  endtask

  initial begin
    rst_n            = 1'b0;
    mvd_if.mvd_start = 1'b0;
    mvd_if.mvd_x     = 16'd0;
    mvd_if.mvd_y     = 16'd0;
    mvd_if.bin_rdy   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mvd_rdy", 32'(mvd_if.mvd_rdy), 1);
    chk("rst_bin_vld", 32'(mvd_if.bin_vld), 0);
    chk("rst_bin_val", 32'(mvd_if.bin_val), 0);
    chk("rst_bin_ep", 32'(mvd_if.bin_ep), 0);
    chk("rst_ctx", 32'(mvd_if.bin_ctx_addr), 0);
    chk("rst_done", 32'(mvd_if.mvd_done), 0);
`ifdef MVD_BIN_CNT_EN
    chk("rst_cnt", 32'(mvd_if.mvd_bin_cnt), 0);
`endif
    rst_n = 1'b1;

    run_pair(0, 0, 0, -1, 0, 0);
    run_pair(1, -1, 0, -1, 0, 0);
    run_pair(5, 0, 0, -1, 0, 0);
    run_pair(5, 0, 0, 1, 3, 0);
    run_pair(-32768, 32767, 0, -1, 0, 0);
    run_pair(32767, -32768, 0, -1, 0, 0);
    run_pair(2, -2, 0, -1, 0, 1);
    run_pair(-3, 6, 1, 4, 2, 1);

    // Reset while emitting the first EG1 prefix bin of x
    @(negedge clk);
    mvd_if.mvd_x     = 16'd5;
    mvd_if.mvd_y     = 16'd0;
    mvd_if.mvd_start = 1'b1;
    mvd_if.bin_rdy   = 1'b1;
    @(negedge clk);
    mvd_if.mvd_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("egp_x_vld", 32'(mvd_if.bin_vld), 1);
    chk("egp_x_ep", 32'(mvd_if.bin_ep), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_vld", 32'(mvd_if.bin_vld), 0);
    chk("abort_rdy", 32'(mvd_if.mvd_rdy), 1);
    chk("abort_done", 32'(mvd_if.mvd_done), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_done", 32'(mvd_if.mvd_done), 0);
      chk("post_abort_vld", 32'(mvd_if.bin_vld), 0);
    end
    run_pair(0, 0, 0, -1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      int x;
      int y;
      if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 65535)) - 32768;
      else                           x = int'($urandom_range(0, 12)) - 6;
      if ($urandom_range(0, 3) == 0) y = int'($urandom_range(0, 65535)) - 32768;
      else                           y = int'($urandom_range(0, 12)) - 6;
      run_pair(x, y, 1, -1, 0, (t % 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
